// File: rtl/fsm_ctrl_pkg.sv
// Shared state encodings and width helpers for the FIFO-monitor controller.
package fsm_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder; index is 0 when no request bit is set.
module prio_enc_lsb
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 9,
  localparam int unsigned ID_W = idx_width(NUM_FIFOS)
) (
  input  logic [NUM_FIFOS-1:0] req,
  output logic [ID_W-1:0]      idx
);

  logic found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (req[i] && !found) begin
        idx   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_ctrl_param.sv
// FIFO-bank monitor FSM with threshold latching and sticky error capture.
// Optional threshold validity check enabled by defining FSM_TH_CHECK_EN.
module fsm_ctrl_param
  import fsm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FIFOS = 9,
  parameter int unsigned TH_WIDTH  = 3,
  localparam int unsigned ID_W = idx_width(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [TH_WIDTH-1:0]  th_almost_full,
  input  logic [TH_WIDTH-1:0]  th_almost_empty,
  input  logic [NUM_FIFOS-1:0] fifos_empty,
  input  logic [NUM_FIFOS-1:0] fifos_error,
  output logic [TH_WIDTH-1:0]  th_fifos_almost_full,
  output logic [TH_WIDTH-1:0]  th_fifos_almost_empty,
  output logic                 idle,
  output logic                 active,
  output logic                 error_out,
  output logic [ID_W-1:0]      error_id,
  output logic                 th_invalid,
  output logic [STATE_W-1:0]   state
);

  logic [STATE_W-1:0] state_next;
  logic [ID_W-1:0]    enc_idx;
  logic               th_ok;
  logic               any_error;
  logic               all_empty;

  prio_enc_lsb #(.NUM_FIFOS(NUM_FIFOS)) u_prio_enc (
    .req (fifos_error),
    .idx (enc_idx)
  );

`ifdef FSM_TH_CHECK_EN
  assign th_ok = (th_almost_empty < th_almost_full);
`else
  assign th_ok = 1'b1;
`endif

  assign any_error = |fifos_error;
  assign all_empty = &fifos_empty;

  // Priority inside each state: error, then init, then empty-based move.
  always_comb begin
    state_next = state;
    case (state)
      ST_RESET:  state_next = ST_INIT;
      ST_INIT: begin
        if (any_error)           state_next = ST_ERROR;
        else if (!init && th_ok) state_next = ST_IDLE;
        else                     state_next = ST_INIT;
      end
      ST_IDLE: begin
        if (any_error)       state_next = ST_ERROR;
        else if (init)       state_next = ST_INIT;
        else if (!all_empty) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (any_error)      state_next = ST_ERROR;
        else if (init)      state_next = ST_INIT;
        else if (all_empty) state_next = ST_IDLE;
      end
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= ST_RESET;
      th_fifos_almost_full  <= '0;
      th_fifos_almost_empty <= '0;
      error_id              <= '0;
      th_invalid            <= 1'b0;
    end else begin
      state      <= state_next;
      th_invalid <= (state_next == ST_INIT) && !th_ok;
      if (state == ST_INIT) begin
        th_fifos_almost_full  <= th_almost_full;
        th_fifos_almost_empty <= th_almost_empty;
      end
      if (state_next == ST_ERROR && state != ST_ERROR)
        error_id <= enc_idx;
    end
  end

  assign idle      = (state == ST_IDLE);
  assign active    = (state == ST_ACTIVE);
  assign error_out = (state == ST_ERROR);

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Table-driven bench for fsm_ctrl_param; expectations adapt to FSM_TH_CHECK_EN.
module tb_fsm_ctrl_param;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [2:0] th_almost_full, th_almost_empty;
  logic [8:0] fifos_empty, fifos_error;
  logic [2:0] th_fifos_almost_full, th_fifos_almost_empty;
  logic       idle, active, error_out, th_invalid;
  logic [3:0] error_id;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  fsm_ctrl_param #(.NUM_FIFOS(9), .TH_WIDTH(3)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .init                  (init),
    .th_almost_full        (th_almost_full),
    .th_almost_empty       (th_almost_empty),
    .fifos_empty           (fifos_empty),
    .fifos_error           (fifos_error),
    .th_fifos_almost_full  (th_fifos_almost_full),
    .th_fifos_almost_empty (th_fifos_almost_empty),
    .idle                  (idle),
    .active                (active),
    .error_out             (error_out),
    .error_id              (error_id),
    .th_invalid            (th_invalid),
    .state                 (state)
  );

  typedef struct {
    logic       rst;
    logic       ini;
    logic [2:0] thf;
    logic [2:0] the;
    logic [8:0] emp;
    logic [8:0] err;
    logic [2:0] st;
    logic [3:0] id;
    logic [2:0] tf;
    logic [2:0] te;
    logic       inv;
  } vec_t;

  vec_t vecs[$];

`ifdef FSM_TH_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic add(input logic rst, input logic ini, input logic [2:0] thf,
                     input logic [2:0] the, input logic [8:0] emp,
                     input logic [8:0] err, input logic [2:0] st,
                     input logic [3:0] id, input logic [2:0] tf,
                     input logic [2:0] te, input logic inv);
    vec_t v;
    v.rst = rst; v.ini = ini; v.thf = thf; v.the = the; v.emp = emp; v.err = err;
    v.st = st; v.id = id; v.tf = tf; v.te = te; v.inv = inv;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [3:0] id,
                       input logic [2:0] tf, input logic [2:0] te, input logic inv);
    logic [15:0] got, exp;
    got = {state, idle, active, error_out, error_id, th_fifos_almost_full,
           th_fifos_almost_empty, th_invalid};
    exp = {st, st == 3'd2, st == 3'd3, st == 3'd4, id, tf, te, inv};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got st=%0d idle=%0b act=%0b err=%0b id=%0d tf=%0d te=%0d inv=%0b, need st=%0d idle=%0b act=%0b err=%0b id=%0d tf=%0d te=%0d inv=%0b",
                  name, state, idle, active, error_out, error_id, th_fifos_almost_full,
                  th_fifos_almost_empty, th_invalid, st, st == 3'd2, st == 3'd3,
                  st == 3'd4, id, tf, te, inv);
  endtask

  task automatic drive(input logic rst, input logic ini, input logic [2:0] thf,
                       input logic [2:0] the, input logic [8:0] emp, input logic [8:0] err);
    reset = rst; init = ini; th_almost_full = thf; th_almost_empty = the;
    fifos_empty = emp; fifos_error = err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_defaults();
    //   rst ini thf the emp     err     | st id tf te inv
    add(1, 0, 0, 0, 9'h1FF, 9'h000, 0, 0, 0, 0, 0);  // reset
    add(1, 0, 0, 0, 9'h1FF, 9'h000, 0, 0, 0, 0, 0);
    add(0, 1, 6, 2, 9'h1FF, 9'h000, 1, 0, 0, 0, 0);  // RESET->INIT, no load yet
    add(0, 1, 6, 2, 9'h1FF, 9'h000, 1, 0, 6, 2, 0);  // INIT loads
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 2, 0, 6, 2, 0);  // exit to IDLE
    add(0, 0, 6, 2, 9'h1FE, 9'h000, 3, 0, 6, 2, 0);  // ACTIVE
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 2, 0, 6, 2, 0);  // IDLE
    add(0, 0, 6, 2, 9'h0FF, 9'h000, 3, 0, 6, 2, 0);  // MSB not empty
    add(0, 0, 1, 7, 9'h0FF, 9'h000, 3, 0, 6, 2, 0);  // thresholds held
    add(0, 0, 1, 7, 9'h1FE, 9'h014, 4, 2, 6, 2, 0);  // error id 2
    add(0, 1, 6, 2, 9'h1FF, 9'h000, 4, 2, 6, 2, 0);  // sticky through init
    add(0, 1, 6, 2, 9'h1FF, 9'h1FF, 4, 2, 6, 2, 0);  // new errors ignored
    add(1, 0, 6, 2, 9'h1FF, 9'h000, 0, 0, 0, 0, 0);  // reset clears ERROR
    add(0, 0, 2, 5, 9'h1FF, 9'h000, 1, 0, 0, 0, CHECK_EN);
    if (CHECK_EN) begin
      add(0, 0, 2, 5, 9'h1FF, 9'h000, 1, 0, 2, 5, 1);  // held in INIT
      add(0, 1, 6, 2, 9'h1FF, 9'h000, 1, 0, 6, 2, 0);
    end else begin
      add(0, 0, 2, 5, 9'h1FF, 9'h000, 2, 0, 2, 5, 0);  // no check: IDLE
      add(0, 1, 6, 2, 9'h1FF, 9'h000, 1, 0, 2, 5, 0);  // IDLE->INIT, hold
    end
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 2, 0, 6, 2, 0);
    add(0, 1, 6, 2, 9'h1FF, 9'h001, 4, 0, 6, 2, 0);  // error beats init
    add(1, 0, 6, 2, 9'h1FF, 9'h000, 0, 0, 0, 0, 0);
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 1, 0, 0, 0, 0);
    add(0, 1, 5, 3, 9'h1FF, 9'h100, 4, 8, 5, 3, 0);  // error from INIT, id 8
    add(1, 0, 6, 2, 9'h1FF, 9'h000, 0, 0, 0, 0, 0);
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 1, 0, 0, 0, 0);
    add(0, 0, 6, 2, 9'h1FF, 9'h000, 2, 0, 6, 2, 0);
    add(0, 1, 6, 2, 9'h1FE, 9'h000, 1, 0, 6, 2, 0);  // init beats activity
    add(0, 0, 5, 4, 9'h1FF, 9'h000, 2, 0, 5, 4, 0);
    add(0, 0, 5, 4, 9'h1FF, 9'h000, 2, 0, 5, 4, 0);  // stays IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ini, vecs[i].thf, vecs[i].the, vecs[i].emp, vecs[i].err);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].id, vecs[i].tf, vecs[i].te, vecs[i].inv);
    end

    // Reset taken mid-ACTIVE, then re-entry via INIT.
    drive(0, 0, 5, 4, 9'h0F0, 9'h000);
    check("seq_active", 3'd3, 4'd0, 3'd5, 3'd4, 1'b0);
    drive(1, 0, 5, 4, 9'h0F0, 9'h000);
    check("seq_rst_active", 3'd0, 4'd0, 3'd0, 3'd0, 1'b0);
    drive(0, 0, 7, 1, 9'h0F0, 9'h000);
    check("seq_reinit", 3'd1, 4'd0, 3'd0, 3'd0, 1'b0);
    drive(0, 0, 7, 1, 9'h0F0, 9'h000);
    check("seq_idle", 3'd2, 4'd0, 3'd7, 3'd1, 1'b0);
    drive(0, 0, 7, 1, 9'h0F0, 9'h000);
    check("seq_active2", 3'd3, 4'd0, 3'd7, 3'd1, 1'b0);
    drive(0, 0, 7, 1, 9'h0F0, 9'h0C0);
    check("seq_err_id6", 3'd4, 4'd6, 3'd7, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  task automatic drive_defaults();
    reset = 1'b1; init = 1'b0; th_almost_full = '0; th_almost_empty = '0;
    fifos_empty = '1; fifos_error = '0;
  endtask

endmodule

// File: doc/fsm_ctrl_param.md
FSM_CTRL_PARAM -- requirements
Module: fsm_ctrl_param

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 9: number of monitored FIFOs.
REQ-002 SHALL have parameter TH_WIDTH, default 3: width of almost-full/almost-empty thresholds.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port init, input, 1: request to enter or stay in INIT and reload thresholds.
REQ-006 SHALL have port th_almost_full, input, TH_WIDTH: candidate almost-full threshold.
REQ-007 SHALL have port th_almost_empty, input, TH_WIDTH: candidate almost-empty threshold.
REQ-008 SHALL have port fifos_empty, input, NUM_FIFOS: per-FIFO empty flags.
REQ-009 SHALL have port fifos_error, input, NUM_FIFOS: per-FIFO overflow/underflow pulses.
REQ-010 SHALL have port th_fifos_almost_full, output, TH_WIDTH: latched almost-full threshold.
REQ-011 SHALL have port th_fifos_almost_empty, output, TH_WIDTH: latched almost-empty threshold.
REQ-012 SHALL have port idle, output, 1: high when in state IDLE.
REQ-013 SHALL have port active, output, 1: high when in state ACTIVE.
REQ-014 SHALL have port error_out, output, 1: high when in state ERROR.
REQ-015 SHALL have port error_id, output, max(1,$clog2(NUM_FIFOS)): index of the FIFO that caused ERROR.
REQ-016 SHALL have port th_invalid, output, 1: high while in INIT with thresholds rejected.
REQ-017 SHALL have port state, output, 3: current state encoding.

Function
REQ-018 SHALL implement states RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4 in one registered state variable.
REQ-019 SHALL derive all outputs from registers, with no combinational path from inputs to outputs.
REQ-020 SHALL transition RESET->INIT one cycle after reset deasserts.
REQ-021 SHALL, in INIT, load th_almost_full/th_almost_empty into th_fifos_* every cycle.
REQ-022 SHALL leave INIT for IDLE when init=0 and thresholds are valid (th_almost_empty < th_almost_full); otherwise INIT SHALL be held.
REQ-023 SHALL hold th_fifos_* unchanged in all states other than INIT.
REQ-024 SHALL, in IDLE, go to ACTIVE when any fifos_empty bit is 0.
REQ-025 SHALL, in ACTIVE, go to IDLE when all fifos_empty bits are 1.
REQ-026 SHALL, from IDLE or ACTIVE, go to INIT when init=1.
REQ-027 SHALL, from IDLE, ACTIVE or INIT, go to ERROR when any fifos_error bit is 1.
REQ-028 SHALL apply event priority error > init > empty-based transition.
REQ-029 SHALL, on entering ERROR, latch error_id as the lowest set index of fifos_error.
REQ-030 SHALL make ERROR sticky, left only via reset; init and fifos_error SHALL be ignored while in ERROR.
REQ-031 SHALL make idle/active/error_out/state reflect the new state one cycle after the triggering input is sampled.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, force state=RESET and drive idle, active, error_out, th_invalid, error_id and th_fifos_* to 0, including mid-operation and in ERROR.

Configuration
REQ-033 SHALL, with FSM_TH_CHECK_EN defined, apply the threshold validity check of REQ-022 and drive th_invalid=1 in INIT when thresholds fail it.
REQ-034 SHALL, without FSM_TH_CHECK_EN, exit INIT on init=0 regardless of threshold values, with th_invalid tied to 0.

Structure
REQ-035 SHALL place the state encodings and the state width constant in shared package fsm_ctrl_pkg.
REQ-036 SHALL implement error_id selection in sub-module prio_enc_lsb, parametrised by NUM_FIFOS.

Verification
REQ-037 Reset check: reset=1 for 2 cycles, then 0 -> state 0 then 1; all outputs 0.
REQ-038 INIT exit: init=1 with th_almost_full=6, th_almost_empty=2, then init=0 -> IDLE next cycle, th_fifos_almost_full=6, th_fifos_almost_empty=2, idle=1.
REQ-039 Activity toggle: fifos_empty=9'h1FF->9'h1FE->9'h1FF -> idle, active, idle on consecutive cycles.
REQ-040 Error capture: fifos_error=9'h014 while active -> error_out=1, error_id=2; stays in ERROR through init=1 and until reset.
REQ-041 Bad thresholds (FSM_TH_CHECK_EN): th_almost_full=2, th_almost_empty=5, init=0 -> remains in INIT, th_invalid=1; without the macro -> IDLE.
REQ-042 Priority: fifos_error=1 and init=1 in the same cycle from IDLE -> ERROR, error_id=0.
